// File: rtl/fft_bitrev_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_buf_if
// Purpose  : Bundle of the butterfly-side write stream and the frequency-
//            ordered output stream of the FFT bit-reversal reorder buffer.
// Signals  : in_vld                       - one butterfly pair per cycle
//            yp_re/yp_im, yq_re/yq_im     - the two butterfly results (signed)
//            out_rdy                      - downstream accepts the sample
//            out_vld, out_re, out_im      - natural-order output sample
//            out_idx, out_last            - bin index and end-of-frame marker
// Modports : master - the environment (butterfly producer + output consumer)
//            slave  - the reorder buffer itself
// Revision : 1.0 - initial release
// ============================================================================
interface fft_bitrev_buf_if #(
    parameter int LOG2N = 8,
    parameter int DW    = 16
);
    logic                    in_vld;
    logic signed [DW-1:0]    yp_re;
    logic signed [DW-1:0]    yp_im;
    logic signed [DW-1:0]    yq_re;
    logic signed [DW-1:0]    yq_im;

    logic                    out_rdy;
    logic                    out_vld;
    logic signed [DW-1:0]    out_re;
    logic signed [DW-1:0]    out_im;
    logic [LOG2N-1:0]        out_idx;
    logic                    out_last;

    modport master (
        output in_vld, yp_re, yp_im, yq_re, yq_im, out_rdy,
        input  out_vld, out_re, out_im, out_idx, out_last
    );

    modport slave (
        input  in_vld, yp_re, yp_im, yq_re, yq_im, out_rdy,
        output out_vld, out_re, out_im, out_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fft_bitrev_buf.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_buf
// Purpose  : Ping-pong reorder buffer behind the last radix-2 DIF butterfly.
//            Each valid input cycle stores the pair (yp, yq) at bank
//            addresses 2*pk and 2*pk+1; a completed bank is streamed out in
//            natural frequency order by reading address bitrev(n). One bank
//            can be filled while the other drains.
// Ports    : clk       - clock, all logic on the rising edge
//            rst_n     - synchronous reset, ACTIVE HIGH despite the name
//            bus       - fft_bitrev_buf_if.slave (input pairs, output stream)
//            ovf       - sticky dropped-pair flag (optional, see below)
// Options  : FFT_BITREV_OVF_EN - when defined, adds the ovf port and logic.
//            Without it, pairs arriving at a full bank are dropped silently.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_buf #(
    parameter int LOG2N = 8,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_bitrev_buf_if.slave    bus
`ifdef FFT_BITREV_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int NPTS  = 1 << LOG2N;
    localparam int NPAIR = NPTS / 2;
    localparam int PW    = LOG2N - 1;
    localparam int SW    = 2 * DW;

    localparam logic [PW-1:0]    PK_LAST  = PW'(NPAIR - 1);
    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(NPTS - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // ------------------------------------------------------------------------
    // Storage. Each bank address a is split by its LSB: yp (even addresses)
    // lives in mem_even, yq (odd addresses) in mem_odd, both indexed by
    // {bank, a[LOG2N-1:1]} = {bank, pk}. This gives one write port per array
    // while still storing a whole pair per cycle.
    // ------------------------------------------------------------------------
    logic [SW-1:0]      mem_even [NPTS];
    logic [SW-1:0]      mem_odd  [NPTS];

    // Write side
    bank_state_t        bank_q [2];
    bank_state_t        bank_d [2];
    logic               wb_q, wb_d;
    logic [PW-1:0]      pk_q, pk_d;
    logic               wr_en;
    logic               wr_last;

    // Read side
    rd_state_t          rd_state_q, rd_state_d;
    logic               rb_q, rb_d;
    logic [LOG2N:0]     rd_cnt_q, rd_cnt_d;   // MSB set once a full frame has been fetched
    logic [LOG2N-1:0]   rd_addr;
    logic [SW-1:0]      rd_word;
    logic               rd_issue;
    logic               rd_free;

    // Output register and skid entry
    logic               out_vld_q, out_vld_d;
    logic [SW-1:0]      out_word_q, out_word_d;
    logic [LOG2N-1:0]   out_idx_q, out_idx_d;
    logic               skid_vld_q, skid_vld_d;
    logic [SW-1:0]      skid_word_q, skid_word_d;
    logic [LOG2N-1:0]   skid_idx_q, skid_idx_d;
    logic               out_load;
    logic               out_take;
    logic               out_last;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Write side: a pair is accepted unless the target bank still holds an
    // unread frame; in that case it is dropped and pk holds so the writer
    // resumes at the same position once the bank is released.
    // ------------------------------------------------------------------------
    assign wr_en   = bus.in_vld && (bank_q[wb_q] != BANK_FULL);
    assign wr_last = wr_en && (pk_q == PK_LAST);

    always_comb begin
        pk_d = pk_q;
        wb_d = wb_q;
        if (wr_en) begin
            pk_d = pk_q + 1'b1;          // wraps to 0 after the last pair
            if (wr_last) begin
                wb_d = ~wb_q;
            end
        end
    end

    // A bank being written is never FULL and a bank being freed is always
    // FULL, so the two updates below can never target the same bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (wr_en && (wb_q == 1'(b))) begin
                if (wr_last) begin
                    bank_d[b] = BANK_FULL;
                end else begin
                    bank_d[b] = BANK_FILLING;
                end
            end
            if (rd_free && (rb_q == 1'(b))) begin
                bank_d[b] = BANK_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_even[{wb_q, pk_q}] <= {bus.yp_re, bus.yp_im};
            mem_odd [{wb_q, pk_q}] <= {bus.yq_re, bus.yq_im};
        end
    end

    // ------------------------------------------------------------------------
    // Read side. A fetch is issued only while the skid entry is empty, which
    // keeps out_rdy out of the RAM address path; the skid absorbs the one
    // fetch already in flight when a stall begins, so a steady out_rdy=1
    // stream has no bubbles.
    // ------------------------------------------------------------------------
    assign rd_addr  = bitrev(rd_cnt_q[LOG2N-1:0]);
    assign rd_word  = rd_addr[0] ? mem_odd [{rb_q, rd_addr[LOG2N-1:1]}]
                                 : mem_even[{rb_q, rd_addr[LOG2N-1:1]}];
    assign rd_issue = (rd_state_q == RD_READ) && !rd_cnt_q[LOG2N] && !skid_vld_q;

    assign out_last = out_vld_q && (out_idx_q == IDX_LAST);
    assign out_take = out_vld_q && bus.out_rdy;
    assign out_load = !out_vld_q || bus.out_rdy;
    // The bank is released on the handshake of its last bin, not when that
    // bin was fetched, so the reader stays in READ until then.
    assign rd_free  = out_take && out_last;

    always_comb begin
        rd_state_d = rd_state_q;
        rb_d       = rb_q;
        rd_cnt_d   = rd_cnt_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (bank_q[rb_q] == BANK_FULL) begin
                    rd_state_d = RD_READ;
                    rd_cnt_d   = '0;
                end
            end
            RD_READ: begin
                if (rd_issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (rd_free) begin
                    rd_state_d = RD_IDLE;
                    rb_d       = ~rb_q;
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    // Output register is refilled from the skid first (older sample), then
    // directly from a fresh fetch. A fetch that cannot enter the output
    // register lands in the skid. Skid valid implies output valid.
    always_comb begin
        out_vld_d   = out_vld_q;
        out_word_d  = out_word_q;
        out_idx_d   = out_idx_q;
        skid_vld_d  = skid_vld_q;
        skid_word_d = skid_word_q;
        skid_idx_d  = skid_idx_q;
        if (out_load) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_word_d = skid_word_q;
                out_idx_d  = skid_idx_q;
                skid_vld_d = 1'b0;
            end else if (rd_issue) begin
                out_vld_d  = 1'b1;
                out_word_d = rd_word;
                out_idx_d  = rd_cnt_q[LOG2N-1:0];
            end else begin
                out_vld_d  = 1'b0;
            end
        end else if (rd_issue) begin
            skid_vld_d  = 1'b1;
            skid_word_d = rd_word;
            skid_idx_d  = rd_cnt_q[LOG2N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            bank_q[0]   <= BANK_EMPTY;
            bank_q[1]   <= BANK_EMPTY;
            wb_q        <= 1'b0;
            pk_q        <= '0;
            rd_state_q  <= RD_IDLE;
            rb_q        <= 1'b0;
            rd_cnt_q    <= '0;
            out_vld_q   <= 1'b0;
            out_word_q  <= '0;
            out_idx_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_word_q <= '0;
            skid_idx_q  <= '0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            wb_q        <= wb_d;
            pk_q        <= pk_d;
            rd_state_q  <= rd_state_d;
            rb_q        <= rb_d;
            rd_cnt_q    <= rd_cnt_d;
            out_vld_q   <= out_vld_d;
            out_word_q  <= out_word_d;
            out_idx_q   <= out_idx_d;
            skid_vld_q  <= skid_vld_d;
            skid_word_q <= skid_word_d;
            skid_idx_q  <= skid_idx_d;
        end
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_re   = out_word_q[SW-1:DW];
    assign bus.out_im   = out_word_q[DW-1:0];
    assign bus.out_idx  = out_idx_q;
    assign bus.out_last = out_last;

`ifdef FFT_BITREV_OVF_EN
    // ------------------------------------------------------------------------
    // Sticky overflow: set by the first pair that meets a full bank.
    // ------------------------------------------------------------------------
    logic ovf_q;
    logic wr_drop;

    assign wr_drop = bus.in_vld && (bank_q[wb_q] == BANK_FULL);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ovf_q <= 1'b0;
        end else if (wr_drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bitrev_buf
// Purpose  : Directed self-checking bench for fft_bitrev_buf. Pair k of a
//            frame carries yp=(2k, tag), yq=(2k+1, tag), so output bin n must
//            read back re=bitrev8(n), im=tag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_buf;

    localparam int LOG2N = 8;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fft_bitrev_buf_if #(.LOG2N(LOG2N), .DW(DW)) bus ();

`ifdef FFT_BITREV_OVF_EN
    logic ovf;
`endif

    fft_bitrev_buf #(.LOG2N(LOG2N), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FFT_BITREV_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    function automatic logic [7:0] bitrev8(input int n);
        logic [7:0] v;
        logic [7:0] r;
        v = n[7:0];
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input bit vld, input int k, input int tag);
        bus.in_vld = vld;
        bus.yp_re  = DW'(2 * k);
        bus.yp_im  = DW'(tag);
        bus.yq_re  = DW'(2 * k + 1);
        bus.yq_im  = DW'(tag);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int seen;
        drive_pair(0, 0, 0);
        bus.out_rdy = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        total++;
        if (bus.out_vld !== 1'b0 || bus.out_re !== 16'sd0 || bus.out_im !== 16'sd0 ||
            bus.out_idx !== 8'd0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: vld=%b re=%0d im=%0d idx=%0d last=%b, want all 0",
                     bus.out_vld, bus.out_re, bus.out_im, bus.out_idx, bus.out_last);
        end
`ifdef FFT_BITREV_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf: ovf=%b, want 0", ovf);
        end
`endif
        bus.out_rdy = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (bus.out_vld !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_idle_vld: out_vld seen %0d cycles, want 0", seen);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_single_frame();
        int n, cyc;
        bus.out_rdy = 1'b1;
        for (int k = 0; k < 128; k++) begin
            drive_pair(1, k, 1);
            tick();
        end
        // the last pair was written at the edge just passed (T)
        drive_pair(0, 0, 0);
        tick();
        total++;
        if (bus.out_vld !== 1'b0) begin
            bad++;
            $display("FAIL latency_t1: out_vld=%b at T+1, want 0", bus.out_vld);
        end
        tick();
        total++;
        if (bus.out_vld !== 1'b1 || bus.out_idx !== 8'd0) begin
            bad++;
            $display("FAIL latency_t2: out_vld=%b idx=%0d at T+2, want vld=1 idx=0",
                     bus.out_vld, bus.out_idx);
        end
        n = 0;
        cyc = 0;
        while (n < 256 && cyc < 600) begin
            if (bus.out_vld === 1'b1) begin
                total++;
                if (bus.out_idx !== 8'(n) || bus.out_re !== DW'(bitrev8(n)) ||
                    bus.out_im !== 16'sd1 || bus.out_last !== (n == 255)) begin
                    bad++;
                    $display("FAIL single_beat: idx=%0d re=%0d im=%0d last=%b, want idx=%0d re=%0d im=1 last=%b",
                             bus.out_idx, bus.out_re, bus.out_im, bus.out_last,
                             n, bitrev8(n), (n == 255));
                end
                n++;
            end
            tick();
            cyc++;
        end
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL single_count: beats=%0d, want 256", n);
        end
        // spot values called out explicitly: bin 1 -> 128, bin 2 -> 64
        total++;
        if (bitrev8(1) !== 8'd128 || bitrev8(2) !== 8'd64) begin
            bad++;
            $display("FAIL bitrev_model: b(1)=%0d b(2)=%0d, want 128 64", bitrev8(1), bitrev8(2));
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        int b, cyc, n, f;
        bus.out_rdy = 1'b1;
        fork
            begin
                for (int fr = 0; fr < 4; fr++) begin
                    for (int k = 0; k < 128; k++) begin
                        drive_pair(1, k, 10 + fr);
                        tick();
                    end
                    drive_pair(0, 0, 0);
                    repeat (132) tick();
                end
            end
            begin
                b = 0;
                cyc = 0;
                while (b < 1024 && cyc < 1500) begin
                    if (bus.out_vld === 1'b1) begin
                        n = b % 256;
                        f = b / 256;
                        total++;
                        if (bus.out_idx !== 8'(n) || bus.out_re !== DW'(bitrev8(n)) ||
                            bus.out_im !== DW'(10 + f) || bus.out_last !== (n == 255)) begin
                            bad++;
                            $display("FAIL b2b_beat: idx=%0d re=%0d im=%0d, want idx=%0d re=%0d im=%0d",
                                     bus.out_idx, bus.out_re, bus.out_im, n, bitrev8(n), 10 + f);
                        end
                        b++;
                    end
                    tick();
                    cyc++;
                end
            end
        join
        total++;
        if (b != 1024) begin
            bad++;
            $display("FAIL b2b_count: beats=%0d, want 1024", b);
        end
`ifdef FFT_BITREV_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ovf: ovf=%b, want 0", ovf);
        end
`endif
    endtask

    // ------------------------------------------------------------------------
    task automatic test_backpressure();
        int n, cyc, stalled;
        logic [DW-1:0]    h_re, h_im;
        logic [LOG2N-1:0] h_idx;
        bus.out_rdy = 1'b0;
        for (int k = 0; k < 128; k++) begin
            drive_pair(1, k, 5);
            tick();
        end
        drive_pair(0, 0, 0);
        n = 0;
        cyc = 0;
        stalled = 0;
        h_re = '0;
        h_im = '0;
        h_idx = '0;
        while (n < 256 && cyc < 1000) begin
            if (stalled != 0) begin
                total++;
                if (bus.out_vld !== 1'b1 || bus.out_idx !== h_idx ||
                    bus.out_re !== h_re || bus.out_im !== h_im) begin
                    bad++;
                    $display("FAIL bp_hold: vld=%b idx=%0d re=%0d im=%0d, want vld=1 idx=%0d re=%0d im=%0d",
                             bus.out_vld, bus.out_idx, bus.out_re, bus.out_im, h_idx, h_re, h_im);
                end
            end
            bus.out_rdy = ~bus.out_rdy;
            stalled = 0;
            if (bus.out_vld === 1'b1) begin
                if (bus.out_rdy === 1'b1) begin
                    total++;
                    if (bus.out_idx !== 8'(n) || bus.out_re !== DW'(bitrev8(n)) ||
                        bus.out_im !== 16'sd5 || bus.out_last !== (n == 255)) begin
                        bad++;
                        $display("FAIL bp_beat: idx=%0d re=%0d im=%0d, want idx=%0d re=%0d im=5",
                                 bus.out_idx, bus.out_re, bus.out_im, n, bitrev8(n));
                    end
                    n++;
                end else begin
                    stalled = 1;
                    h_re  = bus.out_re;
                    h_im  = bus.out_im;
                    h_idx = bus.out_idx;
                end
            end
            tick();
            cyc++;
        end
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL bp_count: beats=%0d, want 256", n);
        end
        bus.out_rdy = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_overflow();
        int b, cyc, n, f, seen;
        bus.out_rdy = 1'b0;
        for (int g = 0; g < 300; g++) begin
            drive_pair(1, g % 128, 20 + g / 128);
            tick();
        end
        drive_pair(0, 0, 0);
`ifdef FFT_BITREV_OVF_EN
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: ovf=%b, want 1", ovf);
        end
`endif
        bus.out_rdy = 1'b1;
        b = 0;
        cyc = 0;
        while (b < 512 && cyc < 800) begin
            if (bus.out_vld === 1'b1) begin
                n = b % 256;
                f = b / 256;
                total++;
                if (bus.out_idx !== 8'(n) || bus.out_re !== DW'(bitrev8(n)) ||
                    bus.out_im !== DW'(20 + f)) begin
                    bad++;
                    $display("FAIL ovf_beat: idx=%0d re=%0d im=%0d, want idx=%0d re=%0d im=%0d",
                             bus.out_idx, bus.out_re, bus.out_im, n, bitrev8(n), 20 + f);
                end
                b++;
            end
            tick();
            cyc++;
        end
        total++;
        if (b != 512) begin
            bad++;
            $display("FAIL ovf_count: beats=%0d, want 512", b);
        end
        seen = 0;
        repeat (30) begin
            if (bus.out_vld !== 1'b0) seen++;
            tick();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL ovf_extra: out_vld seen %0d cycles after 512 beats, want 0", seen);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_read();
        int n, cyc, seen;
        bus.out_rdy = 1'b1;
        for (int k = 0; k < 128; k++) begin
            drive_pair(1, k, 30);
            tick();
        end
        // partial next frame, to be discarded by the reset
        for (int k = 0; k < 40; k++) begin
            drive_pair(1, k, 99);
            tick();
        end
        drive_pair(0, 0, 0);
        cyc = 0;
        while (!(bus.out_vld === 1'b1 && bus.out_idx === 8'd100) && cyc < 400) begin
            tick();
            cyc++;
        end
        total++;
        if (!(bus.out_vld === 1'b1 && bus.out_idx === 8'd100)) begin
            bad++;
            $display("FAIL rst_mid_reach: vld=%b idx=%0d, want vld=1 idx=100", bus.out_vld, bus.out_idx);
        end
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        total++;
        if (bus.out_vld !== 1'b0 || bus.out_re !== 16'sd0 || bus.out_im !== 16'sd0 ||
            bus.out_idx !== 8'd0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: vld=%b re=%0d im=%0d idx=%0d last=%b, want all 0",
                     bus.out_vld, bus.out_re, bus.out_im, bus.out_idx, bus.out_last);
        end
`ifdef FFT_BITREV_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_ovf: ovf=%b, want 0", ovf);
        end
`endif
        seen = 0;
        repeat (30) begin
            tick();
            if (bus.out_vld !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rst_mid_quiet: out_vld seen %0d cycles, want 0", seen);
        end
        for (int k = 0; k < 128; k++) begin
            drive_pair(1, k, 31);
            tick();
        end
        drive_pair(0, 0, 0);
        n = 0;
        cyc = 0;
        while (n < 256 && cyc < 600) begin
            if (bus.out_vld === 1'b1) begin
                total++;
                if (bus.out_idx !== 8'(n) || bus.out_re !== DW'(bitrev8(n)) || bus.out_im !== 16'sd31) begin
                    bad++;
                    $display("FAIL rst_mid_new: idx=%0d re=%0d im=%0d, want idx=%0d re=%0d im=31",
                             bus.out_idx, bus.out_re, bus.out_im, n, bitrev8(n));
                end
                n++;
            end
            tick();
            cyc++;
        end
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL rst_mid_count: beats=%0d, want 256", n);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_same_cycle();
        int n, cyc;
        bus.out_rdy = 1'b1;
        for (int k = 0; k < 128; k++) begin
            drive_pair(1, k, 40);
            tick();
        end
        drive_pair(0, 0, 0);
        cyc = 0;
        while (!(bus.out_vld === 1'b1 && bus.out_idx === 8'd128) && cyc < 400) begin
            tick();
            cyc++;
        end
        total++;
        if (!(bus.out_vld === 1'b1 && bus.out_idx === 8'd128)) begin
            bad++;
            $display("FAIL same_reach: vld=%b idx=%0d, want vld=1 idx=128", bus.out_vld, bus.out_idx);
        end
        // pair j presented together with bin 128+j: the last pair meets bin 255
        n = 128;
        for (int j = 0; j < 128; j++) begin
            total++;
            if (bus.out_vld !== 1'b1 || bus.out_idx !== 8'(n) || bus.out_re !== DW'(bitrev8(n)) ||
                bus.out_im !== 16'sd40 || bus.out_last !== (n == 255)) begin
                bad++;
                $display("FAIL same_first: vld=%b idx=%0d re=%0d im=%0d, want vld=1 idx=%0d re=%0d im=40",
                         bus.out_vld, bus.out_idx, bus.out_re, bus.out_im, n, bitrev8(n));
            end
            drive_pair(1, j, 41);
            tick();
            n++;
        end
        drive_pair(0, 0, 0);
        n = 0;
        cyc = 0;
        while (n < 256 && cyc < 600) begin
            if (bus.out_vld === 1'b1) begin
                total++;
                if (bus.out_idx !== 8'(n) || bus.out_re !== DW'(bitrev8(n)) ||
                    bus.out_im !== 16'sd41 || bus.out_last !== (n == 255)) begin
                    bad++;
                    $display("FAIL same_second: idx=%0d re=%0d im=%0d, want idx=%0d re=%0d im=41",
                             bus.out_idx, bus.out_re, bus.out_im, n, bitrev8(n));
                end
                n++;
            end
            tick();
            cyc++;
        end
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL same_count: beats=%0d, want 256", n);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.out_rdy = 1'b0;
        drive_pair(0, 0, 0);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_mid_read();
        test_same_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
